// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters (EX stage = r0, aux/debug = r1) share one
// combinational ALU. Round-robin grant, ALU inputs muxed from the winner, and
// the ALU result captured into a single-entry response register tagged with
// the requester id.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rX_valid / rX_ready        request handshake, X = 0,1
//   rX_a, rX_a2, rX_b, rX_b2   request operands (XLEN)
//   rX_op, rX_brn              request opcode (4b) and branch mode
//   alu_a/a2/b/b2/op/brn       operands to the shared ALU (0 when no grant)
//   alu_out, alu_taken         shared ALU result and branch-taken flag
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_result, rsp_taken  captured response
//   acc_cnt0, acc_cnt1         per-requester accept counters (wrap)
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_a2,
  input  logic [XLEN-1:0] r0_b,
  input  logic [XLEN-1:0] r0_b2,
  input  logic [3:0]      r0_op,
  input  logic            r0_brn,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_a2,
  input  logic [XLEN-1:0] r1_b,
  input  logic [XLEN-1:0] r1_b2,
  input  logic [3:0]      r1_op,
  input  logic            r1_brn,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_a2,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] alu_b2,
  output logic [3:0]      alu_op,
  output logic            alu_brn,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_taken,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_taken,
  output logic [CNTW-1:0] acc_cnt0,
  output logic [CNTW-1:0] acc_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] a2;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] b2;
    logic [3:0]      op;
    logic            brn;
  } req_t;

  state_t                 state, state_nxt;
  req_t   [1:0]           req;
  req_t                   sel;
  logic   [1:0]           vld;
  logic   [1:0]           rdy;
  logic   [1:0][CNTW-1:0] cnt;
  logic                   rr_last;   // id of the most recent winner
  logic                   gnt_vld, gnt_id, can_accept, accept;

  assign req[0] = {r0_a, r0_a2, r0_b, r0_b2, r0_op, r0_brn};
  assign req[1] = {r1_a, r1_a2, r1_b, r1_b2, r1_op, r1_brn};
  assign vld    = {r1_valid, r0_valid};

  // r1 wins when it is alone, or when both ask and r0 won last time.
  assign gnt_vld    = |vld;
  assign gnt_id     = vld[1] & (~vld[0] | ~rr_last);
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign accept     = can_accept & gnt_vld;

  // ALU mux follows the grant alone so the ALU result is valid the same
  // cycle even while the response slot is blocked.
  assign sel = gnt_vld ? req[gnt_id] : '0;
  assign {alu_a, alu_a2, alu_b, alu_b2, alu_op, alu_brn} = sel;

  assign rdy[0]   = accept & ~gnt_id;
  assign rdy[1]   = accept &  gnt_id;
  assign r0_ready = rdy[0];
  assign r1_ready = rdy[1];

  assign rsp_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (!accept && rsp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Response slot: an accept overwrites it, which also covers the
  // consume-and-reload case on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_taken  <= 1'b0;
      rr_last    <= 1'b1;
    end else if (accept) begin
      rsp_id     <= gnt_id;
      rsp_result <= alu_out;
      rsp_taken  <= alu_taken;
      rr_last    <= gnt_id;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt[g] <= '0;
      else if (rdy[g]) cnt[g] <= cnt[g] + 1'b1;
    end
  end

  assign acc_cnt0 = cnt[0];
  assign acc_cnt1 = cnt[1];

endmodule
